sd_cmd_tx: RTL

SD_CMD_TX -- requirements
Module: sd_cmd_tx

---
 rtl/sd_cmd_tx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sd_cmd_tx.sv
// ---------------------------------------------------------------------------
// sd_cmd_tx : SD card CMD-line transmitter.
//
// Serialises one 48-bit SD command frame
//   {start bit 0, transmission bit 1, cmd_index[5:0], cmd_arg[31:0], crc7, end bit 1}
// MSB first onto the CMD line. The CRC7 is not computed here. The 40-bit
// frame head goes to an external CRC7 stage, and the result is merged into
// the frame before shifting starts.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high
//   start      : send request, only looked at in IDLE
//   cmd_index  : 6-bit command index, captured when start is accepted
//   cmd_arg    : 32-bit argument, captured when start is accepted
//   busy       : high whenever the FSM is not in IDLE
//   done       : one-cycle pulse after the end bit has been sent
//   crc_load   : one-cycle strobe to the CRC7 stage (LOAD state)
//   crc_data   : frame head handed to the CRC7 stage, held until next start
//   crc_ready  : CRC7 stage result-valid flag, sampled in WAIT_CRC only
//   crc_in     : CRC7 result, valid while crc_ready=1
//   cmd_out    : serial CMD data (idles high)
//   cmd_oe     : CMD output enable, high only while bits are being shifted
//   dbg_state  : current FSM state encoding, for observation only
//
// Handshake: start is a level that is consumed only in the IDLE cycle it is
// seen in; it is never queued. crc_ready is qualified only in WAIT_CRC, so a
// flag left high by a previous computation during LOAD is not mistaken for
// the new result.
// ---------------------------------------------------------------------------
module sd_cmd_tx #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    output logic        busy,
    output logic        done,
    output logic        crc_load,
    output logic [39:0] crc_data,
    input  logic        crc_ready,
    input  logic [6:0]  crc_in,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_WAIT_CRC = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam logic [7:0] LAST_CYC = 8'(BIT_CYCLES - 1);
    localparam logic [5:0] LAST_BIT = 6'd47;

    state_t      state_q, state_d;
    logic [47:0] shift_q, shift_d;
    logic [39:0] crc_data_q, crc_data_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  cyc_cnt_q, cyc_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            crc_data_q <= '0;
            bit_cnt_q  <= '0;
            cyc_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            crc_data_q <= crc_data_d;
            bit_cnt_q  <= bit_cnt_d;
            cyc_cnt_q  <= cyc_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        crc_data_d = crc_data_q;
        bit_cnt_d  = bit_cnt_q;
        cyc_cnt_d  = cyc_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // CRC field is zero until the CRC7 stage answers.
                    shift_d    = {1'b0, 1'b1, cmd_index, cmd_arg, 7'b0, 1'b1};
                    // Separate copy: the shift register moves, the CRC stage
                    // must keep seeing a stable head.
                    crc_data_d = {1'b0, 1'b1, cmd_index, cmd_arg};
                    bit_cnt_d  = '0;
                    cyc_cnt_d  = '0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT_CRC;
            end
            ST_WAIT_CRC: begin
                if (crc_ready) begin
                    shift_d[7:1] = crc_in;
                    bit_cnt_d    = '0;
                    cyc_cnt_d    = '0;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cyc_cnt_q == LAST_CYC) begin
                    cyc_cnt_d = '0;
                    shift_d   = {shift_q[46:0], 1'b1};
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end else begin
                    cyc_cnt_d = cyc_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode straight from the state register so that an
    // asynchronous reset drives them to their idle values immediately.
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign crc_load  = (state_q == ST_LOAD);
    assign crc_data  = crc_data_q;
    assign cmd_oe    = (state_q == ST_SHIFT);
    assign cmd_out   = (state_q == ST_SHIFT) ? shift_q[47] : 1'b1;
    assign dbg_state = state_q;

endmodule
